// File: rtl/ram_sdp_be_if.sv
// Bus bundle for the single-clock byte-enabled SDP RAM: write port, read port
// and clear-engine control/status.
interface ram_sdp_be_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic                   wr_en;
    logic [A_WIDTH-1:0]     wr_addr;
    logic [D_WIDTH-1:0]     wr_data;
    logic [D_WIDTH/8-1:0]   wr_be;
    logic                   rd_en;
    logic [A_WIDTH-1:0]     rd_addr;
    logic [D_WIDTH-1:0]     rd_data;
    logic                   rd_valid;
    logic                   clr_req;
    logic                   init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/ram_sdp_be.sv
// Single-clock simple-dual-port RAM with byte enables, write-first forwarding,
// a read-valid strobe, an optional output register and a hardware clear engine.
module ram_sdp_be #(
    parameter int D_WIDTH        = 32,
    parameter int A_WIDTH        = 5,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_sdp_be_if.slave     bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam int NB    = D_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic   RST_BUSY  = (CLEAR_ON_RESET != 0);

    // Take new bytes where the enable is set, keep the old bytes elsewhere.
    function automatic logic [D_WIDTH-1:0] byte_merge(
        input logic [D_WIDTH-1:0] old_w,
        input logic [D_WIDTH-1:0] new_w,
        input logic [NB-1:0]      be
    );
        logic [D_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic               busy_q;

    logic               idle_s, wr_acc_s, rd_acc_s;
    logic               mem_we_s;
    logic [A_WIDTH-1:0] mem_waddr_s;
    logic [D_WIDTH-1:0] mem_wdata_s;
    logic [NB-1:0]      mem_be_s;
    logic [D_WIDTH-1:0] rd_raw_s, rd_fwd_s;

    logic               s0_vld_q;
    logic [D_WIDTH-1:0] s0_data_q;
    logic               pre_vld_s;
    logic [D_WIDTH-1:0] pre_data_s;
    logic               rd_valid_q;
    logic [D_WIDTH-1:0] rd_data_q;

    assign idle_s   = (state_q == ST_IDLE);
    assign wr_acc_s = idle_s & bus.wr_en;
    assign rd_acc_s = idle_s & bus.rd_en;

    // Clear-engine FSM: next state and sweep counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (&clr_cnt_q) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(A_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Clear-engine state, counter and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            busy_q    <= RST_BUSY;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    // Array write port: the clear sweep owns it while active, otherwise the user.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.wr_addr;
        mem_wdata_s = bus.wr_data;
        mem_be_s    = bus.wr_be;
        if (!rst_n) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = '0;
            mem_be_s    = '1;
        end else begin
            mem_we_s = wr_acc_s;
        end
    end

    // Storage array; deliberately not reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be_s[i]) begin
                    mem_q[mem_waddr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Write-first: a same-edge write to the read address is folded into the read.
    always_comb begin
        rd_raw_s = mem_q[bus.rd_addr];
        if (wr_acc_s && (bus.wr_addr == bus.rd_addr)) begin
            rd_fwd_s = byte_merge(rd_raw_s, bus.wr_data, bus.wr_be);
        end else begin
            rd_fwd_s = rd_raw_s;
        end
    end

    // Read sample stage: captures the addressed word at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q  <= 1'b0;
            s0_data_q <= '0;
        end else begin
            s0_vld_q <= rd_acc_s;
            if (rd_acc_s) begin
                s0_data_q <= rd_fwd_s;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic               s1_vld_q;
            logic [D_WIDTH-1:0] s1_data_q;

            // Optional extra pipeline stage for timing closure.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q <= s0_vld_q;
                    if (s0_vld_q) begin
                        s1_data_q <= s0_data_q;
                    end
                end
            end

            assign pre_vld_s  = s1_vld_q;
            assign pre_data_s = s1_data_q;
        end else begin : g_no_out_reg
            assign pre_vld_s  = s0_vld_q;
            assign pre_data_s = s0_data_q;
        end
    endgenerate

    // Output register: rd_data only moves when a result is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pre_vld_s;
            if (pre_vld_s) begin
                rd_data_q <= pre_data_s;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = busy_q;
endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Single-clock simple-dual-port RAM: one write port, one read port; generalised successor of the existing two-clock RAM.
- Adds per-byte write enables, write-first read-during-write forwarding, a read-valid strobe and an optional output pipeline register.
- Adds a hardware clear engine that zeroes the array after reset or on request.
- Used as a register-file / scratchpad store inside single-clock datapaths.

Parameters:
- D_WIDTH, 32, data width in bits; must be a multiple of 8.
- A_WIDTH, 5, address width; depth DEPTH = 2**A_WIDTH.
- OUT_REG, 1, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- CLEAR_ON_RESET, 1, 1 = run the clear engine automatically when reset deasserts; 0 = clear only on clr_req.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  A_WIDTH  write address.
- wr_data  input  D_WIDTH  write data.
- wr_be  input  D_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  A_WIDTH  read address.
- rd_data  output  D_WIDTH  read data; holds its last value when rd_valid=0.
- rd_valid  output  1  one-cycle strobe marking rd_data valid.
- clr_req  input  1  pulse requesting a full-array clear.
- init_busy  output  1  high while the clear engine runs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_data=0, rd_valid=0; all read pipeline registers and valid bits = 0; clr_cnt=0.
  - State = CLEAR with init_busy=1 if CLEAR_ON_RESET=1; otherwise state = IDLE with init_busy=0.
  - Memory contents are not reset by rst_n.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1 at a clock edge; init_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to memory[clr_cnt], then clr_cnt++.
  - After writing address DEPTH-1: state -> IDLE, clr_cnt -> 0, init_busy=0 in the following cycle.
  - A clear occupies exactly DEPTH cycles with init_busy=1.
- During CLEAR:
  - wr_en and rd_en are ignored; requests are dropped, not queued.
  - clr_req is ignored; an active clear never restarts.
  - No new rd_valid is generated.
- Reads already in the pipeline when CLEAR starts complete normally with the data captured at issue.
- Reset asserted mid-clear: aborts the clear; after deassertion it restarts from address 0 if CLEAR_ON_RESET=1.
- Write (IDLE only): on posedge with wr_en=1, memory[wr_addr] byte i <= wr_data byte i for every i with wr_be[i]=1. Other bytes are unchanged. wr_be=0 is a no-op.
- Read (IDLE only): rd_en=1 at edge N samples memory[rd_addr].
  - OUT_REG=0: rd_data/rd_valid update at edge N+1.
  - OUT_REG=1: rd_data/rd_valid update at edge N+2.
  - Back-to-back reads give one result per cycle at full throughput, in order.
- Read-during-write, same address, same edge (IDLE): write-first.
  - Returned data takes wr_data bytes where wr_be=1 and old memory bytes elsewhere.
  - Memory is updated identically.
- Different addresses on the same edge: read and write are fully independent.
- rd_valid is high for exactly one cycle per accepted read.
- Address wrap: addresses are plain A_WIDTH indices with no out-of-range case.

Test Plan:
- CLEAR_ON_RESET=1, A_WIDTH=5: release rst_n -> init_busy=1 for exactly 32 cycles; rd_en/wr_en ignored meanwhile; then reads of addresses 0..31 all return 0.
- Write addr 3 = 0xDEADBEEF, wr_be=4'b1111; then write addr 3 = 0x11223344 with wr_be=4'b0101; read addr 3 -> rd_data=0xDE22BE44 with rd_valid 1 cycle after rd_en (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- Same edge: write addr 7 = 0xAAAA5555, wr_be=4'b0011, old content 0x12345678, plus read addr 7 -> rd_data=0x12345555; a later read also returns 0x12345555.
- Streaming reads of addresses 0..7 on consecutive cycles after loading value = address -> rd_valid high for 8 consecutive cycles; rd_data = 0..7 in order.
- Issue a read of addr 2 (holding 0x55), then assert clr_req on the next cycle -> the read returns 0x55 with rd_valid; init_busy rises; a mid-clear clr_req does not extend the clear (still 32 busy cycles).
- Assert rst_n=0 at clear cycle 10 -> rd_valid=0 and rd_data=0 immediately; after release the clear reruns for a full 32 cycles.
